score_event_scheduler: RTL and testbench

Sits between the obstacle lanes and the score counter. It collects "obstacle passed" events from N lanes, which may fire in the same cycle, and queues them per lane. It then serves the lanes round-robin and replays each queued event as a clean, separated pulse on `score_increment`. The score counter counts rising edges, so simultaneous events would otherwise merge into one point; this block prevents that.

---
 rtl/score_pkg.sv | 18 +
 rtl/rr_picker.sv | 35 +++
 rtl/score_event_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_score_event_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score path: scheduler FSM states and default pulse timing.
// The score counter and display logic import this package as well.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } sched_state_t;

    localparam int DEF_PULSE_CYC = 1;
    localparam int DEF_GAP_CYC   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps
// modulo N_LANES, so the most recently served lane has the lowest priority.
module rr_picker #(
    parameter int N_LANES = 4,
    parameter int LW      = $clog2(N_LANES)
) (
    input  logic [N_LANES-1:0] req,
    input  logic [LW-1:0]      last_grant,
    output logic               grant_valid,
    output logic [LW-1:0]      grant_idx
);

    int          sum;
    logic [LW-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = 0;
        cand        = '0;
        for (int k = 1; k <= N_LANES; k++) begin
            // last_grant < N_LANES and k <= N_LANES, so one subtraction suffices to wrap
            sum = int'(last_grant) + k;
            if (sum >= N_LANES) begin
                sum = sum - N_LANES;
            end
            cand = sum[LW-1:0];
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/score_event_scheduler.sv
// Queues per-lane "obstacle passed" events and replays them one at a time as separated
// pulses on score_increment, so simultaneous events are never merged by the edge counter.
module score_event_scheduler
    import score_pkg::*;
#(
    parameter int  N_LANES   = 4,
    parameter int  CNT_W     = 3,
    parameter int  PULSE_CYC = DEF_PULSE_CYC,
    parameter int  GAP_CYC   = DEF_GAP_CYC,
    localparam int LW        = $clog2(N_LANES)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N_LANES-1:0] pass_evt,
    input  logic               game_active,
    input  logic               clear_pending,
    output logic               score_increment,
    output logic [LW-1:0]      grant_lane,
    output logic               busy,
    output logic               dropped
);

    localparam int                TMR_W      = $clog2(max_int(PULSE_CYC, GAP_CYC)) + 1;
    localparam logic [TMR_W-1:0]  PULSE_LAST = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST   = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [LW-1:0]     LAST_INIT  = LW'(N_LANES - 1);

    sched_state_t     state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] pend_q [N_LANES];
    logic [CNT_W-1:0] pend_d [N_LANES];
    logic [LW-1:0]    grant_lane_q, grant_lane_d;
    logic [LW-1:0]    last_grant_q, last_grant_d;
    logic             score_increment_q, score_increment_d;
    logic             busy_q, busy_d;
    logic             dropped_q, dropped_d;

    logic [N_LANES-1:0] req;
    logic [N_LANES-1:0] lane_inc;
    logic [N_LANES-1:0] lane_dec;
    logic               grant_valid;
    logic [LW-1:0]      grant_idx;
    logic               can_grant;
    logic               grant_fire;
    logic               drop_any;

    always_comb begin
        req = '0;
        for (int i = 0; i < N_LANES; i++) begin
            req[i] = (pend_q[i] != '0);
        end
    end

    rr_picker #(
        .N_LANES (N_LANES),
        .LW      (LW)
    ) u_rr_picker (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A flush in progress blocks new grants; only an already-started pulse/gap completes.
    assign can_grant = grant_valid && !clear_pending;

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        grant_fire   = 1'b0;
        grant_lane_d = grant_lane_q;
        last_grant_d = last_grant_q;

        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    grant_fire = 1'b1;
                    state_d    = S_PULSE;
                    tmr_d      = '0;
                end
            end
            S_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d = S_GAP;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                // The last gap cycle arbitrates as IDLE would, keeping back-to-back throughput.
                if (tmr_q == GAP_LAST) begin
                    tmr_d = '0;
                    if (can_grant) begin
                        grant_fire = 1'b1;
                        state_d    = S_PULSE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        if (grant_fire) begin
            grant_lane_d = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    always_comb begin
        lane_inc = clear_pending ? '0 : (pass_evt & {N_LANES{game_active}});
        lane_dec = '0;
        if (grant_fire) begin
            lane_dec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        drop_any = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            pend_d[i] = pend_q[i];
            if (clear_pending) begin
                pend_d[i] = '0;
            end else if (lane_inc[i] && !lane_dec[i]) begin
                if (pend_q[i] == CNT_MAX) begin
                    drop_any = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + CNT_W'(1);
                end
            end else if (lane_dec[i] && !lane_inc[i]) begin
                pend_d[i] = pend_q[i] - CNT_W'(1);
            end
        end

        dropped_d = clear_pending ? 1'b0 : (dropped_q || drop_any);

        busy_d = (state_d != S_IDLE);
        for (int i = 0; i < N_LANES; i++) begin
            if (pend_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end

        score_increment_d = (state_d == S_PULSE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q           <= S_IDLE;
            tmr_q             <= '0;
            grant_lane_q      <= '0;
            last_grant_q      <= LAST_INIT;
            score_increment_q <= 1'b0;
            busy_q            <= 1'b0;
            dropped_q         <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q           <= state_d;
            tmr_q             <= tmr_d;
            grant_lane_q      <= grant_lane_d;
            last_grant_q      <= last_grant_d;
            score_increment_q <= score_increment_d;
            busy_q            <= busy_d;
            dropped_q         <= dropped_d;
            for (int i = 0; i < N_LANES; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign score_increment = score_increment_q;
    assign grant_lane      = grant_lane_q;
    assign busy            = busy_q;
    assign dropped         = dropped_q;

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed bench for score_event_scheduler with default parameters (4 lanes, 1/1 pulse/gap).
module tb_score_event_scheduler;

    localparam int N = 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] pass_evt = '0;
    logic         game_active = 1'b0;
    logic         clear_pending = 1'b0;
    logic         score_increment;
    logic [1:0]   grant_lane;
    logic         busy;
    logic         dropped;

    int n_checks = 0;
    int n_pass   = 0;

    // Downstream edge counter model: counts rising edges and logs the lane of each pulse.
    int         pulse_cnt = 0;
    int         lane_cnt [N];
    logic [1:0] lane_log [$];
    logic       prev_si = 1'b0;

    score_event_scheduler #(
        .N_LANES   (4),
        .CNT_W     (3),
        .PULSE_CYC (1),
        .GAP_CYC   (1)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .pass_evt        (pass_evt),
        .game_active     (game_active),
        .clear_pending   (clear_pending),
        .score_increment (score_increment),
        .grant_lane      (grant_lane),
        .busy            (busy),
        .dropped         (dropped)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (score_increment && !prev_si) begin
            pulse_cnt            <= pulse_cnt + 1;
            lane_cnt[grant_lane] <= lane_cnt[grant_lane] + 1;
            lane_log.push_back(grant_lane);
        end
        prev_si <= score_increment;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        pass_evt      = '0;
        clear_pending = 1'b0;
        game_active   = 1'b1;
        step(2);
        Reset = 1'b0;
    endtask

    initial begin
        int base;
        int base0;
        int base2;
        int lb;

        // Reset state
        do_reset();
        check("rst_score",   32'(score_increment), 0);
        check("rst_grant",   32'(grant_lane), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_dropped", 32'(dropped), 0);

        // Single event on lane 0
        base = pulse_cnt;
        pass_evt = 4'b0001;
        step();
        pass_evt = '0;
        check("single_t1_score", 32'(score_increment), 0);
        check("single_t1_busy",  32'(busy), 1);
        step();
        check("single_t2_score", 32'(score_increment), 1);
        check("single_t2_grant", 32'(grant_lane), 0);
        step();
        check("single_t3_score", 32'(score_increment), 0);
        step();
        check("single_t4_busy",  32'(busy), 0);
        check("single_pulses",   32'(pulse_cnt - base), 1);

        // Simultaneous events on all lanes
        do_reset();
        base = pulse_cnt;
        pass_evt = 4'b1111;
        step();
        pass_evt = '0;
        for (int k = 2; k <= 9; k++) begin
            step();
            check($sformatf("simul_score_t%0d", k), 32'(score_increment), (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) begin
                check($sformatf("simul_grant_t%0d", k), 32'(grant_lane), (k - 2) / 2);
            end
        end
        step();
        check("simul_busy_end", 32'(busy), 0);
        check("simul_pulses",   32'(pulse_cnt - base), 4);

        // Saturation: lanes 0 and 2 held for 10 cycles
        do_reset();
        base0 = lane_cnt[0];
        base2 = lane_cnt[2];
        pass_evt = 4'b0101;
        step(10);
        pass_evt = '0;
        check("sat_dropped", 32'(dropped), 1);
        check("sat_busy",    32'(busy), 1);
        step(40);
        check("sat_busy_end",    32'(busy), 0);
        check("sat_lane0_total", 32'(lane_cnt[0] - base0), 10);
        check("sat_lane2_total", 32'(lane_cnt[2] - base2), 9);
        check("sat_dropped_hold", 32'(dropped), 1);

        // Fairness: lanes 0 and 3 held continuously
        do_reset();
        lb = lane_log.size();
        pass_evt = 4'b1001;
        step(20);
        pass_evt = '0;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("fair_order_%0d", j), 32'(lane_log[lb + j]), (j % 2 == 0) ? 0 : 3);
        end
        check("fair_dropped", 32'(dropped), 1);
        clear_pending = 1'b1;
        step();
        clear_pending = 1'b0;
        check("clr_dropped", 32'(dropped), 0);
        step(4);
        check("clr_busy_end", 32'(busy), 0);

        // Gating: game inactive ignores events
        do_reset();
        game_active = 1'b0;
        base = pulse_cnt;
        pass_evt = 4'b0011;
        step();
        check("gate_busy_t1", 32'(busy), 0);
        step(2);
        pass_evt = '0;
        step(3);
        check("gate_pulses", 32'(pulse_cnt - base), 0);
        check("gate_busy",   32'(busy), 0);
        game_active = 1'b1;

        // Flush while a pulse is in flight
        do_reset();
        base = pulse_cnt;
        pass_evt = 4'b0001;
        step(4);
        check("flush_t4_score", 32'(score_increment), 1);
        clear_pending = 1'b1;
        step();
        clear_pending = 1'b0;
        pass_evt = '0;
        check("flush_t5_score",   32'(score_increment), 0);
        check("flush_t5_dropped", 32'(dropped), 0);
        step();
        check("flush_t6_busy", 32'(busy), 0);
        step(6);
        check("flush_pulses", 32'(pulse_cnt - base), 2);

        // Reset during a pulse
        do_reset();
        pass_evt = 4'b1111;
        step();
        pass_evt = '0;
        step();
        check("mid_rst_pre_score", 32'(score_increment), 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid_rst_score",   32'(score_increment), 0);
        check("mid_rst_grant",   32'(grant_lane), 0);
        check("mid_rst_busy",    32'(busy), 0);
        check("mid_rst_dropped", 32'(dropped), 0);
        base = pulse_cnt;
        step(4);
        check("mid_rst_lost_pulses", 32'(pulse_cnt - base), 0);
        check("mid_rst_lost_busy",   32'(busy), 0);
        pass_evt = 4'b1001;
        step();
        pass_evt = '0;
        step();
        check("post_rst_score", 32'(score_increment), 1);
        check("post_rst_grant", 32'(grant_lane), 0);
        step(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
